// File: rtl/prio_pkt_arb.sv
// Two-source packet arbiter: source 0 has fixed priority, grants are held for a whole packet,
// and a starvation counter forces one source-1 packet after STARVE_LIM contended source-0 packets.
// Optional statistics counters are built when PRIO_PKT_ARB_STATS_EN is defined.
module prio_pkt_arb #(
    parameter int DATA_W     = -1,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 8,
    // Keeps port widths legal if the payload width is left at its unset default
    localparam int DW        = (DATA_W > 0) ? DATA_W : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src0_val,
    input  logic [DW-1:0] src0_data,
    input  logic          src0_last,
    output logic          src0_rdy,
    input  logic          src1_val,
    input  logic [DW-1:0] src1_data,
    input  logic          src1_last,
    output logic          src1_rdy,
    output logic          dst_val,
    output logic [DW-1:0] dst_data,
    output logic          dst_last,
    input  logic          dst_rdy,
    output logic          dst_src
`ifdef PRIO_PKT_ARB_STATS_EN
    ,
    output logic [31:0]   stat_pkt0,
    output logic [31:0]   stat_pkt1,
    output logic [15:0]   stat_force
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    typedef struct packed {
        logic          val;
        logic [DW-1:0] data;
        logic          last;
    } flit_t;

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             force1;
    logic             gnt_vld;
    logic             gnt;
    logic             xfer;
    logic             first_xfer;
    flit_t            flit0, flit1, sel;

    assign flit0 = '{val: src0_val, data: src0_data, last: src0_last};
    assign flit1 = '{val: src1_val, data: src1_data, last: src1_last};

    assign force1 = src1_val && (starve_cnt == LIM);

    // Grant is recomputed every cycle in IDLE; a lock pins it until the last flit.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (force1) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b1;
                end else if (src0_val) begin
                    gnt_vld = 1'b1;
                end else if (src1_val) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b1;
                end
            end
            LOCK0: gnt_vld = 1'b1;
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt     = 1'b1;
            end
            default: ;
        endcase
    end

    // Output process: combinational datapath, source 0 shows through when ungranted
    always_comb begin
        sel      = gnt ? flit1 : flit0;
        dst_val  = gnt_vld & sel.val;
        dst_data = sel.data;
        dst_last = sel.last;
        dst_src  = gnt;
        src0_rdy = gnt_vld & ~gnt & dst_rdy;
        src1_rdy = gnt_vld &  gnt & dst_rdy;
    end

    assign xfer       = dst_val & dst_rdy;
    assign first_xfer = xfer && (state == IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (xfer && !dst_last)
                    state_nxt = gnt ? LOCK1 : LOCK0;
            end
            LOCK0, LOCK1: begin
                if (xfer && dst_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Counts contended source-0 packet starts; any other packet start clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (first_xfer) begin
            if (gnt || !src1_val)
                starve_cnt <= '0;
            else if (starve_cnt != LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef PRIO_PKT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_pkt0  <= '0;
            stat_pkt1  <= '0;
            stat_force <= '0;
        end else begin
            if (xfer && dst_last && !gnt)
                stat_pkt0 <= stat_pkt0 + 32'd1;
            if (xfer && dst_last && gnt)
                stat_pkt1 <= stat_pkt1 + 32'd1;
            if (first_xfer && force1)
                stat_force <= stat_force + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prio_pkt_arb.sv
// Directed bench for prio_pkt_arb: single source, lock hold, idle re-arbitration,
// reset mid-packet, starvation forcing and backpressure, with hand-computed expectations.
module tb_prio_pkt_arb;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              src0_val, src0_last, src0_rdy;
    logic [DATA_W-1:0] src0_data;
    logic              src1_val, src1_last, src1_rdy;
    logic [DATA_W-1:0] src1_data;
    logic              dst_val, dst_last, dst_rdy, dst_src;
    logic [DATA_W-1:0] dst_data;
`ifdef PRIO_PKT_ARB_STATS_EN
    logic [31:0]       stat_pkt0, stat_pkt1;
    logic [15:0]       stat_force;
`endif

    int total = 0;
    int bad   = 0;

    prio_pkt_arb #(.DATA_W(DATA_W), .STARVE_LIM(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .src0_val  (src0_val),
        .src0_data (src0_data),
        .src0_last (src0_last),
        .src0_rdy  (src0_rdy),
        .src1_val  (src1_val),
        .src1_data (src1_data),
        .src1_last (src1_last),
        .src1_rdy  (src1_rdy),
        .dst_val   (dst_val),
        .dst_data  (dst_data),
        .dst_last  (dst_last),
        .dst_rdy   (dst_rdy),
        .dst_src   (dst_src)
`ifdef PRIO_PKT_ARB_STATS_EN
        ,
        .stat_pkt0 (stat_pkt0),
        .stat_pkt1 (stat_pkt1),
        .stat_force(stat_force)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1,
                         input logic rdy);
        src0_val = v0; src0_data = d0; src0_last = l0;
        src1_val = v1; src1_data = d1; src1_last = l1;
        dst_rdy  = rdy;
        #1;
    endtask

    int exp_src[10];
    int exp_cnt[10];

    initial begin
        exp_src = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        exp_cnt = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

        // Reset state
        rst = 1'b0;
        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
        chk("rst_dst_val", dst_val, 0);
        chk("rst_rdy0", src0_rdy, 0);
        chk("rst_rdy1", src1_rdy, 0);
        chk("rst_dst_src", dst_src, 0);
        chk("rst_state", dut.state, 0);
        chk("rst_cnt", dut.starve_cnt, 0);
        tick; tick;
        rst = 1'b1;
        #1;

        // Single source: 3-flit packet from source 1
        drive(0, 8'h00, 0, 1, 8'hA1, 0, 1);
        chk("s1_f1_val", dst_val, 1);
        chk("s1_f1_src", dst_src, 1);
        chk("s1_f1_rdy1", src1_rdy, 1);
        chk("s1_f1_rdy0", src0_rdy, 0);
        chk("s1_f1_data", dst_data, 8'hA1);
        tick;
        chk("s1_lock1", dut.state, 2);
        drive(0, 8'h00, 0, 1, 8'hA2, 0, 1);
        chk("s1_f2_data", dst_data, 8'hA2);
        chk("s1_f2_rdy0", src0_rdy, 0);
        chk("s1_f2_last", dst_last, 0);
        tick;
        drive(0, 8'h00, 0, 1, 8'hA3, 1, 1);
        chk("s1_f3_last", dst_last, 1);
        chk("s1_f3_rdy0", src0_rdy, 0);
        tick;
        chk("s1_idle", dut.state, 0);
        chk("s1_cnt", dut.starve_cnt, 0);

        // Lock hold: source 0 arrives mid-packet and waits
        drive(0, 8'h00, 0, 1, 8'hB1, 0, 1);
        tick;
        drive(1, 8'hC0, 1, 1, 8'hB2, 0, 1);
        chk("lk_f2_rdy0", src0_rdy, 0);
        chk("lk_f2_data", dst_data, 8'hB2);
        chk("lk_f2_src", dst_src, 1);
        tick;
        drive(1, 8'hC0, 1, 1, 8'hB3, 1, 1);
        chk("lk_f3_rdy0", src0_rdy, 0);
        chk("lk_f3_last", dst_last, 1);
        tick;
        drive(1, 8'hC0, 1, 0, 8'h00, 0, 1);
        chk("lk_idle", dut.state, 0);
        chk("lk_g0_rdy0", src0_rdy, 1);
        chk("lk_g0_src", dst_src, 0);
        chk("lk_g0_data", dst_data, 8'hC0);
        tick;
        chk("lk_cnt", dut.starve_cnt, 0);

        // dst_rdy low in IDLE: newly arriving source 0 displaces a pending source-1 head
        drive(0, 8'h00, 0, 1, 8'hE1, 1, 0);
        chk("idl_src1", dst_src, 1);
        chk("idl_rdy1", src1_rdy, 0);
        chk("idl_val", dst_val, 1);
        drive(1, 8'hE0, 1, 1, 8'hE1, 1, 0);
        chk("idl_src0", dst_src, 0);
        chk("idl_data0", dst_data, 8'hE0);
        tick;
        chk("idl_state", dut.state, 0);
        chk("idl_cnt", dut.starve_cnt, 0);

        // Reset asserted mid-packet in LOCK1
        drive(0, 8'h00, 0, 1, 8'hF1, 0, 1);
        tick;
        chk("rm_lock1", dut.state, 2);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        rst = 1'b0;
        #1;
        chk("rm_state", dut.state, 0);
        chk("rm_cnt", dut.starve_cnt, 0);
        chk("rm_rdy0", src0_rdy, 0);
        chk("rm_rdy1", src1_rdy, 0);
        chk("rm_dst_val", dst_val, 0);
        tick;
        rst = 1'b1;
        #1;

        // Starvation: both sources always valid with single-flit packets
        drive(1, 8'h55, 1, 1, 8'h66, 1, 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("sv_src%0d", i), dst_src, exp_src[i]);
            chk($sformatf("sv_data%0d", i), dst_data, (exp_src[i] == 1) ? 8'h66 : 8'h55);
            tick;
            chk($sformatf("sv_cnt%0d", i), dut.starve_cnt, exp_cnt[i]);
        end
`ifdef PRIO_PKT_ARB_STATS_EN
        chk("st_pkt0", stat_pkt0, 8);
        chk("st_pkt1", stat_pkt1, 2);
        chk("st_force", stat_force, 2);
`endif

        // Backpressure mid-packet on source 0, source 1 waiting
        drive(1, 8'hD1, 0, 1, 8'h71, 1, 1);
        chk("bp_f1_src", dst_src, 0);
        tick;
        chk("bp_lock0", dut.state, 1);
        chk("bp_cnt", dut.starve_cnt, 1);
        drive(1, 8'hD2, 0, 1, 8'h71, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_data%0d", i), dst_data, 8'hD2);
            chk($sformatf("bp_hold_val%0d", i), dst_val, 1);
            chk($sformatf("bp_hold_rdy0_%0d", i), src0_rdy, 0);
            chk($sformatf("bp_hold_rdy1_%0d", i), src1_rdy, 0);
            tick;
            chk($sformatf("bp_hold_state%0d", i), dut.state, 1);
            chk($sformatf("bp_hold_cnt%0d", i), dut.starve_cnt, 1);
        end
        drive(1, 8'hD2, 0, 1, 8'h71, 1, 1);
        chk("bp_f2_rdy0", src0_rdy, 1);
        chk("bp_f2_data", dst_data, 8'hD2);
        tick;
        drive(1, 8'hD3, 1, 1, 8'h71, 1, 1);
        chk("bp_f3_data", dst_data, 8'hD3);
        chk("bp_f3_last", dst_last, 1);
        tick;
        chk("bp_idle", dut.state, 0);
        chk("bp_cnt_end", dut.starve_cnt, 1);
        drive(0, 8'h00, 0, 1, 8'h71, 1, 1);
        chk("bp_g1_src", dst_src, 1);
        tick;
        chk("bp_g1_cnt", dut.starve_cnt, 0);

        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
